lcd_16207_bus_sequencer: RTL and testbench

Avalon-MM slave controller that drives the 16207 (HD44780-class) character LCD with correct bus timing. It sequences address setup, the E pulse, hold and recovery, and stalls the Nios master with waitrequest. It can auto-poll the LCD busy flag after every write, so software never issues a command while the panel is busy. It sits between the Nios data master and the LCD pins, replacing direct pin-level strobing.

---
 rtl/lcd_16207_bus_sequencer.sv | 172 +++++++++++++++++
 tb/tb_lcd_16207_bus_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_16207_bus_sequencer.sv
// Avalon-MM slave that sequences 16207 LCD bus cycles and auto-polls busy.
// Ports: Avalon (address/read/write/writedata/readdata/waitrequest), busy_timeout, LCD_E/RS/RW/data.
module lcd_16207_bus_sequencer #(
  parameter int SETUP_CYC  = 3,
  parameter int PULSE_CYC  = 24,
  parameter int HOLD_CYC   = 2,
  parameter int GAP_CYC    = 24,
  parameter bit AUTO_BUSY  = 1'b1,
  parameter int POLL_LIMIT = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_RECOVER,
    S_POLL
  } state_t;

  localparam logic [7:0]  SETUP_M1 = 8'(SETUP_CYC - 1);
  localparam logic [7:0]  PULSE_M1 = 8'(PULSE_CYC - 1);
  localparam logic [7:0]  HOLD_M1  = 8'(HOLD_CYC - 1);
  localparam logic [7:0]  GAP_M1   = 8'(GAP_CYC - 1);
  localparam logic [15:0] LIMIT    = 16'(POLL_LIMIT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rs_q, rs_d;
  logic        rw_q, rw_d;
  logic [7:0]  data_q, data_d;
  logic        poll_q, poll_d;
  logic        cap7_q, cap7_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        to_q, to_d;
  logic        active;
  logic        drive;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      data_q  <= '0;
      poll_q  <= 1'b0;
      cap7_q  <= 1'b0;
      rdata_q <= '0;
      pcnt_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      poll_q  <= poll_d;
      cap7_q  <= cap7_d;
      rdata_q <= rdata_d;
      pcnt_q  <= pcnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    data_d  = data_q;
    poll_d  = poll_q;
    cap7_d  = cap7_q;
    rdata_d = rdata_q;
    pcnt_d  = pcnt_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (read || write) begin
          rs_d    = address[1];
          // a write always forces RW low, even with address[0] set
          rw_d    = write ? 1'b0 : address[0];
          data_d  = writedata;
          poll_d  = 1'b0;
          cnt_d   = SETUP_M1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = PULSE_M1;
          state_d = S_ENABLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ENABLE: begin
        if (cnt_q == 8'd0) begin
          cap7_d = LCD_data[7];
          if (!poll_q) rdata_d = LCD_data;
          cnt_d   = HOLD_M1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = GAP_M1;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!poll_q && !rw_q && AUTO_BUSY) begin
          pcnt_d  = '0;
          state_d = S_POLL;
        end else if (poll_q && cap7_q) begin
          if (pcnt_q >= LIMIT) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_POLL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POLL: begin
        rs_d    = 1'b0;
        rw_d    = 1'b1;
        poll_d  = 1'b1;
        pcnt_d  = pcnt_q + 16'd1;
        cnt_d   = SETUP_M1;
        state_d = S_SETUP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign active = (state_q == S_SETUP) ||
                  (state_q == S_ENABLE) ||
                  (state_q == S_HOLD);
  // RW only goes low inside an access, so the bus is never driven with RW high
  assign drive  = active && !rw_q;

  assign LCD_E        = (state_q == S_ENABLE);
  assign LCD_RS       = rs_q;
  assign LCD_RW       = active ? rw_q : 1'b1;
  assign LCD_data     = drive ? data_q : 8'bzzzz_zzzz;
  assign waitrequest  = !((state_q == S_HOLD) && (cnt_q == 8'd0) && !poll_q);
  assign readdata     = rdata_q;
  assign busy_timeout = to_q;

endmodule

// File: tb/tb_lcd_16207_bus_sequencer.sv
// Bench for lcd_16207_bus_sequencer: cycle-level expectation queue plus panel model.
// Directed host accesses with literal latency / pulse-count / readdata checks.
module tb_lcd_16207_bus_sequencer;

  localparam int S   = 3;
  localparam int P   = 24;
  localparam int H   = 2;
  localparam int G   = 24;
  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] address = 2'b00;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [7:0] writedata = 8'h00;
  wire  [7:0] readdata;
  wire        waitrequest;
  wire        busy_timeout;
  wire        lcd_e;
  wire        lcd_rs;
  wire        lcd_rw;
  wire  [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_16207_bus_sequencer #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .GAP_CYC(G),
    .AUTO_BUSY(1'b1), .POLL_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest),
    .busy_timeout(busy_timeout), .LCD_E(lcd_e), .LCD_RS(lcd_rs),
    .LCD_RW(lcd_rw), .LCD_data(lcd_data)
  );

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (lcd_data[i]);
  end

  // Panel: answers reads while E is high; status busy for busy_cfg reads.
  int         status_reads = 0;
  int         busy_base = 0;
  int         busy_cfg = 0;
  bit         perm_busy = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic       status_busy;
  logic [7:0] status_v;

  assign status_busy = perm_busy || ((status_reads - busy_base) < busy_cfg);
  assign status_v    = status_busy ? 8'h80 : 8'h00;
  assign lcd_data    = (lcd_e && lcd_rw) ? (lcd_rs ? rd_val : status_v)
                                         : 8'bzzzz_zzzz;

  always @(negedge lcd_e)
    if (lcd_rw && !lcd_rs) status_reads <= status_reads + 1;

  int e_cycles = 0;
  int e_pulses = 0;
  always @(negedge clk) if (lcd_e) e_cycles <= e_cycles + 1;
  always @(posedge lcd_e) e_pulses <= e_pulses + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit         e;
    bit         rs_chk;
    bit         rs;
    bit         rw;
    bit         drv;
    logic [7:0] d;
    bit         wreq;
    bit         rd_chk;
    logic [7:0] rd;
    bit         set_to;
  } exp_t;

  exp_t exp_q[$];
  bit   model_to = 1'b0;

  function automatic exp_t idle_rec();
    exp_t r;
    r.e = 0; r.rs_chk = 0; r.rs = 0; r.rw = 1; r.drv = 0;
    r.d = 8'h00; r.wreq = 1; r.rd_chk = 0; r.rd = 8'h00; r.set_to = 0;
    return r;
  endfunction

  // One bus cycle: setup, E pulse, hold (done on last hold if host), gap.
  function automatic void push_access(bit rs, bit rw, logic [7:0] d,
                                      bit host, logic [7:0] rd);
    exp_t r;
    int n;
    n = S + P + H;
    for (int k = 1; k <= n; k++) begin
      r = idle_rec();
      r.rs_chk = 1; r.rs = rs; r.rw = rw; r.drv = !rw; r.d = d;
      r.e = (k > S) && (k <= S + P);
      if (k == n && host) begin
        r.wreq = 0; r.rd_chk = rw; r.rd = rd;
      end
      exp_q.push_back(r);
    end
    for (int k = 0; k < G; k++) exp_q.push_back(idle_rec());
  endfunction

  function automatic void gen_request();
    bit   rw;
    bit   rs;
    int   busy_n;
    int   polls;
    exp_t r;
    rw = write ? 1'b0 : address[0];
    rs = address[1];
    push_access(rs, rw, writedata, 1'b1, rs ? rd_val : status_v);
    if (!rw) begin
      busy_n = perm_busy ? (1 << 20)
             : busy_cfg - (status_reads - busy_base);
      if (busy_n < 0) busy_n = 0;
      polls = (busy_n < LIM) ? busy_n + 1 : LIM;
      for (int i = 0; i < polls; i++) begin
        exp_q.push_back(idle_rec());
        push_access(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      end
      if (busy_n >= LIM) begin
        r = exp_q.pop_back();
        r.set_to = 1;
        exp_q.push_back(r);
      end
    end
  endfunction

  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        model_to = 1'b0;
        r = idle_rec();
      end else if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
      end else begin
        r = idle_rec();
        if (read || write) gen_request();
      end
      chk("E", 32'(lcd_e), 32'(r.e));
      chk("RW", 32'(lcd_rw), 32'(r.rw));
      chk("WAITREQ", 32'(waitrequest), 32'(r.wreq));
      chk("TIMEOUT", 32'(busy_timeout), 32'(model_to));
      if (r.rs_chk) chk("RS", 32'(lcd_rs), 32'(r.rs));
      if (r.drv) chk("BUS_DRV", 32'(lcd_data), 32'(r.d));
      else if (!r.e) chk("BUS_Z", 32'(lcd_data), 32'h0000_00ff);
      if (r.rd_chk) chk("READDATA", 32'(readdata), 32'(r.rd));
      if (r.set_to) model_to = 1'b1;
    end
  end

  task automatic host_access(bit rd, bit wr, logic [1:0] a, logic [7:0] d,
                             output int lat, output logic [7:0] rdata);
    read = rd; write = wr; address = a; writedata = d;
    lat = -1; rdata = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!waitrequest) begin
        lat = k;
        rdata = readdata;
        break;
      end
    end
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    if (lat < 0) chk("host_wait_expired", 32'(lat), 32'd0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    if (!done) chk("idle_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int         lat;
    int         lat2;
    int         ec0;
    int         ep0;
    logic [7:0] rdat;

    #1;
    chk("rst_E", 32'(lcd_e), 32'd0);
    chk("rst_RW", 32'(lcd_rw), 32'd1);
    chk("rst_RS", 32'(lcd_rs), 32'd0);
    chk("rst_WAITREQ", 32'(waitrequest), 32'd1);
    chk("rst_READDATA", 32'(readdata), 32'd0);
    chk("rst_TIMEOUT", 32'(busy_timeout), 32'd0);
    chk("rst_BUS", 32'(lcd_data), 32'h0000_00ff);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // write 0x41 to data register, panel idle: one poll follows
    ec0 = e_cycles;
    host_access(1'b0, 1'b1, 2'b10, 8'h41, lat, rdat);
    chk("wr41_latency", 32'(lat), 32'd29);
    wait_idle();
    chk("wr41_e_cycles", 32'(e_cycles - ec0), 32'd48);

    // status read, panel busy once
    busy_base = status_reads; busy_cfg = 1;
    ec0 = e_cycles;
    host_access(1'b1, 1'b0, 2'b01, 8'h00, lat, rdat);
    chk("rdst_latency", 32'(lat), 32'd29);
    chk("rdst_data", 32'(rdat), 32'h80);
    wait_idle();
    chk("rdst_e_cycles", 32'(e_cycles - ec0), 32'd24);

    // busy for 3 polls, back-to-back second write stalls
    busy_base = status_reads; busy_cfg = 3;
    ep0 = e_pulses;
    host_access(1'b0, 1'b1, 2'b00, 8'h01, lat, rdat);
    host_access(1'b0, 1'b1, 2'b10, 8'h42, lat2, rdat);
    chk("busy3_latency", 32'(lat), 32'd29);
    chk("busy3_stall_latency", 32'(lat2), 32'd269);
    wait_idle();
    chk("busy3_pulses", 32'(e_pulses - ep0), 32'd7);

    // permanently busy: timeout after POLL_LIMIT polls
    perm_busy = 1'b1;
    ep0 = e_pulses;
    host_access(1'b0, 1'b1, 2'b00, 8'h38, lat, rdat);
    wait_idle();
    chk("perm_pulses", 32'(e_pulses - ep0), 32'd5);
    chk("perm_timeout", 32'(busy_timeout), 32'd1);
    perm_busy = 1'b0;
    rd_val = 8'h5c;
    host_access(1'b1, 1'b0, 2'b11, 8'h00, lat, rdat);
    chk("rddata_latency", 32'(lat), 32'd29);
    chk("rddata_value", 32'(rdat), 32'h5c);
    wait_idle();
    chk("timeout_sticky", 32'(busy_timeout), 32'd1);

    // reset in the middle of the E pulse of a write
    busy_base = status_reads; busy_cfg = 0;
    address = 2'b00; writedata = 8'h0c; write = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    chk("mid_E_high", 32'(lcd_e), 32'd1);
    reset_n = 1'b0; write = 1'b0;
    #1;
    chk("mid_rst_E", 32'(lcd_e), 32'd0);
    chk("mid_rst_RW", 32'(lcd_rw), 32'd1);
    chk("mid_rst_BUS", 32'(lcd_data), 32'h0000_00ff);
    chk("mid_rst_WAITREQ", 32'(waitrequest), 32'd1);
    chk("mid_rst_TIMEOUT", 32'(busy_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    ec0 = e_cycles;
    host_access(1'b0, 1'b1, 2'b00, 8'h0c, lat, rdat);
    chk("post_rst_latency", 32'(lat), 32'd29);
    wait_idle();
    chk("post_rst_e_cycles", 32'(e_cycles - ec0), 32'd48);

    // read and write together: handled as a write
    host_access(1'b1, 1'b1, 2'b01, 8'h5a, lat, rdat);
    chk("rdwr_latency", 32'(lat), 32'd29);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
